// File: rtl/usb_snes_pad_emulator.sv
// rtl/usb_snes_pad_emulator.sv - USB button debounce filter feeding an SNES-style serial pad port
// Buttons are accepted after STABLE_CYCLES+1 unchanged samples, then shifted out LSB first, active-low.
module usb_snes_pad_emulator #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] usb_btn,
  input  logic        pad_latch,
  input  logic        pad_clk,
  output logic        pad_data,
  output logic [11:0] btn_state
);

  localparam logic [15:0] CNT_MAX = 16'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LATCHED, SHIFTING} state_t;

  state_t      state_q, state_d;
  logic [11:0] cand_q, cand_d;
  logic [11:0] btn_q, btn_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] sr_q, sr_d;
  logic [4:0]  bcnt_q, bcnt_d;
  logic        latch_q, clk_q, pd_q;
  logic        clk_rise;

  assign clk_rise  = pad_clk && !clk_q;
  assign pad_data  = pd_q;
  assign btn_state = btn_q;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    btn_d  = btn_q;
    if (usb_btn != cand_q) begin
      cand_d = usb_btn;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      btn_d = cand_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    if (pad_latch) begin
      sr_d    = {4'hF, ~btn_q};
      bcnt_d  = '0;
      state_d = LATCHED;
    end else begin
      case (state_q)
        // latch_q is always set on entry here; anything else is a stale state
        LATCHED: state_d = latch_q ? SHIFTING : IDLE;
        SHIFTING: begin
          if (clk_rise) begin
            sr_d   = {1'b1, sr_q[15:1]};
            bcnt_d = bcnt_q + 5'd1;
            if (bcnt_q == 5'd15) state_d = IDLE;
          end
        end
        IDLE: sr_d = 16'hFFFF;
        default: begin
          state_d = IDLE;
          sr_d    = 16'hFFFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cand_q  <= '0;
      btn_q   <= '0;
      cnt_q   <= '0;
      sr_q    <= 16'hFFFF;
      bcnt_q  <= '0;
      latch_q <= 1'b0;
      clk_q   <= 1'b0;
      pd_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      btn_q   <= btn_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      latch_q <= pad_latch;
      clk_q   <= pad_clk;
      pd_q    <= sr_q[0];
    end
  end

endmodule

// File: tb/tb_usb_snes_pad_emulator.sv
// tb/tb_usb_snes_pad_emulator.sv - directed and random checks of the pad emulator against a behavioural model
module tb_usb_snes_pad_emulator;

  localparam int STABLE = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] usb_btn;
  logic        pad_latch;
  logic        pad_clk;
  logic        pad_data;
  logic [11:0] btn_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usb_snes_pad_emulator #(.STABLE_CYCLES(STABLE)) dut (
    .clk       (clk),
    .reset     (reset),
    .usb_btn   (usb_btn),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .pad_data  (pad_data),
    .btn_state (btn_state)
  );

  // Model: a button value is accepted once the last STABLE+1 samples agree (a reset counts as a 0 sample);
  // a latch captures the 16 output bits, and each clock rise while the latch stays low exposes the next one.
  logic [11:0] hist[$];
  logic [11:0] m_btn;
  logic [15:0] m_bits;
  int          m_k;
  logic        m_prev_clk, m_prev_latch, m_pd;

  always @(posedge clk) begin
    if (!reset) begin
      hist.delete();
      hist.push_back(12'h000);
      m_btn        = 12'h000;
      m_bits       = 16'hFFFF;
      m_k          = 16;
      m_prev_clk   = 1'b0;
      m_prev_latch = 1'b0;
      m_pd         = 1'b1;
    end else begin
      bit same;
      m_pd = (m_k < 16) ? m_bits[m_k] : 1'b1;
      if (pad_latch) begin
        m_bits = {4'hF, ~m_btn};
        m_k    = 0;
      end else if (!m_prev_latch && pad_clk && !m_prev_clk && m_k < 16) begin
        m_k = m_k + 1;
      end
      m_prev_clk   = pad_clk;
      m_prev_latch = pad_latch;
      hist.push_back(usb_btn);
      if (hist.size() > STABLE + 1) void'(hist.pop_front());
      same = (hist.size() == STABLE + 1);
      foreach (hist[i]) if (hist[i] !== hist[0]) same = 1'b0;
      if (same) m_btn = hist[0];
    end
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("model_pad_data", {11'd0, pad_data}, {11'd0, m_pd});
    chk("model_btn_state", btn_state, m_btn);
  endtask

  task automatic latch(input int n);
    pad_clk   = 1'b0;
    pad_latch = 1'b1;
    repeat (n) tick();
    pad_latch = 1'b0;
    tick();
  endtask

  task automatic pulse(input int hi, input int lo);
    pad_clk = 1'b1;
    repeat (hi) tick();
    pad_clk = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] exp_bits;
    int          act;
    reset     = 1'b0;
    usb_btn   = 12'h000;
    pad_latch = 1'b0;
    pad_clk   = 1'b0;
    tick();
    chk("reset_pad_data", {11'd0, pad_data}, 12'h001);
    chk("reset_btn_state", btn_state, 12'h000);
    reset = 1'b1;
    repeat (20) tick();

    // acceptance exactly 17 cycles after the change
    usb_btn = 12'h005;
    for (int t = 1; t <= 40; t++) begin
      tick();
      chk("accept_time", btn_state, (t >= 17) ? 12'h005 : 12'h000);
    end

    // a 10-cycle glitch never reaches btn_state
    do_reset();
    usb_btn = 12'h000;
    repeat (20) tick();
    usb_btn = 12'h0FF;
    repeat (10) begin tick(); chk("glitch10", btn_state, 12'h000); end
    usb_btn = 12'h000;
    repeat (30) begin tick(); chk("glitch10_after", btn_state, 12'h000); end

    // a 16-cycle glitch is still rejected
    usb_btn = 12'h3C3;
    repeat (16) tick();
    usb_btn = 12'h000;
    repeat (20) begin tick(); chk("glitch16", btn_state, 12'h000); end

    // full 16-bit readout with trailing ones
    usb_btn = 12'hA51;
    repeat (20) tick();
    exp_bits = {4'hF, ~12'hA51};
    latch(2);
    chk("readout_bit0", {11'd0, pad_data}, {11'd0, exp_bits[0]});
    for (int k = 1; k <= 18; k++) begin
      pulse(2, 2);
      chk("readout_bit", {11'd0, pad_data}, {11'd0, (k < 16) ? exp_bits[k] : 1'b1});
    end

    // latch and clock rise together mid-shift restart the readout
    latch(1);
    repeat (4) pulse(1, 2);
    pad_latch = 1'b1;
    pad_clk   = 1'b1;
    tick();
    tick();
    chk("latch_priority", {11'd0, pad_data}, {11'd0, ~btn_state[0]});
    pad_latch = 1'b0;
    pad_clk   = 1'b0;
    tick();
    pulse(2, 1);
    chk("latch_priority_bit1", {11'd0, pad_data}, {11'd0, exp_bits[1]});

    // button change mid-shift keeps the latched pattern
    usb_btn = 12'h001;
    repeat (20) tick();
    latch(2);
    repeat (3) pulse(1, 1);
    usb_btn = 12'h800;
    repeat (30) tick();
    chk("midshift_accept", btn_state, 12'h800);
    for (int k = 4; k <= 11; k++) begin
      pulse(1, 1);
      chk("midshift_bit", {11'd0, pad_data}, 12'h001);
    end

    // reset in the middle of a shift
    latch(1);
    repeat (5) pulse(1, 1);
    do_reset();
    chk("midshift_reset_pd", {11'd0, pad_data}, 12'h001);
    chk("midshift_reset_btn", btn_state, 12'h000);
    repeat (20) begin
      pulse(1, 1);
      chk("after_reset_idle", {11'd0, pad_data}, 12'h001);
    end

    // random traffic against the model
    for (int it = 0; it < 300; it++) begin
      act = $urandom_range(0, 19);
      if (act < 6) begin
        usb_btn = 12'($urandom);
        repeat ($urandom_range(1, 25)) tick();
      end else if (act < 9) begin
        latch($urandom_range(1, 3));
      end else if (act < 18) begin
        pulse($urandom_range(1, 3), $urandom_range(1, 3));
      end else if (act < 19) begin
        repeat ($urandom_range(1, 5)) tick();
      end else begin
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
